data_mem_ctrl: RTL and testbench

//   Data-memory stage directly downstream of the ALU: takes ALUResult as a byte

---
 rtl/data_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory stage for RV32I loads/stores with a fixed access latency,
// a req/ack handshake and fault reporting for misaligned or illegal widths.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Busy,
  output logic        Fault
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic            req_fault;
  logic            wr_en;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [31:0]     load_ext;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^ALUResult[31:ADDR_WIDTH];

  always_comb begin
    req_fault = 1'b0;
    case (Funct3)
      3'b000:  req_fault = 1'b0;
      3'b100:  req_fault = MemWrite;
      3'b001:  req_fault = ALUResult[0];
      3'b101:  req_fault = ALUResult[0] | MemWrite;
      3'b010:  req_fault = (ALUResult[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  end

  // Load result: align the addressed lane to bit 0, then extend by width/sign.
  assign rd_shift = rd_word >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    we_d    = we_q;
    f3_d    = f3_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          fault_d = 1'b0;
          rdata_d = we_q ? 32'h0 : load_ext;
        end
      end
      default: begin
        if (Req) begin
          idx_d  = ALUResult[ADDR_WIDTH-1:2];
          lane_d = ALUResult[1:0];
          we_d   = MemWrite;
          f3_d   = Funct3;
          // Replicate store data across lanes so the byte enables pick the right slice.
          case (Funct3[1:0])
            2'b00: begin
              wdata_d = {4{WriteData[7:0]}};
              be_d    = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
              wdata_d = {2{WriteData[15:0]}};
              be_d    = 4'b0011 << ALUResult[1:0];
            end
            default: begin
              wdata_d = WriteData;
              be_d    = 4'b1111;
            end
          endcase
          if (req_fault) begin
            state_d = S_RESP;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign wr_en = (state_q == S_ACCESS) && (cnt_q == 4'd0) && we_q;

  // One byte-wide array per lane; reads track the next index so data is ready by the op edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_en && be_q[gi]) begin
        mem_q[idx_q] <= wdata_q[gi*8 +: 8];
      end
      rd_q <= mem_q[idx_d];
    end
    assign rd_word[gi*8 +: 8] = rd_q;
  end

  assign ReadData = rdata_q;
  assign Ack      = (state_q == S_RESP);
  assign Busy     = (state_q != S_IDLE);
  assign Fault    = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts each
// response at issue time; a negedge monitor checks every Ack against it.
module tb_data_mem_ctrl;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int NB  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Req = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] ReadData;
  logic        Ack;
  logic        Busy;
  logic        Fault;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          edge_n;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [NB];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .Req       (Req),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .Funct3    (Funct3),
    .ReadData  (ReadData),
    .Ack       (Ack),
    .Busy      (Busy),
    .Fault     (Fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Ack must match the oldest outstanding expectation, on the predicted edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && Ack) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_ack cyc=%0d ReadData=%h Fault=%0b required no Ack", cyc, ReadData, Fault);
      end else begin
        e = q.pop_front();
        if (ReadData !== e.data || Fault !== e.fault || cyc != e.edge_n) begin
          errors++;
          $display("FAIL ack_resp got data=%h fault=%0b edge=%0d required data=%h fault=%0b edge=%0d",
                   ReadData, Fault, cyc, e.data, e.fault, e.edge_n);
        end else begin
          $display("ack ok edge=%0d data=%h fault=%0b", cyc, ReadData, Fault);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, expv);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  // Drives a request at a negedge when the DUT will accept it; leaves Req high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    int          g;
    int          a;
    int          sz;
    logic        flt;
    logic [31:0] v;
    exp_t        e;
    g = 0;
    @(negedge clk);
    while (Busy && !Ack && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got busy=%0b required accept within 50 cycles", Busy);
    end
    Req = 1'b1;
    MemWrite = we;
    Funct3 = f3;
    ALUResult = addr;
    WriteData = wd;
    if (!track) return;
    a  = int'(addr & 32'(NB - 1));
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
          (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    v = 32'h0;
    if (!flt) begin
      if (we) begin
        for (int b = 0; b < sz; b++) ref_mem[a + b] = wd[8*b +: 8];
      end else begin
        for (int b = 0; b < sz; b++) v = v | (32'(ref_mem[a + b]) << (8 * b));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      end
    end
    e.data = v;
    e.fault = flt;
    e.edge_n = cyc + 1 + (flt ? 0 : LAT);
    q.push_back(e);
  endtask

  task automatic rel();
    @(negedge clk);
    Req = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || Busy) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    repeat (3) @(negedge clk);
    chk("reset_readdata", ReadData, 32'h0);
    chk("reset_flags", {29'h0, Ack, Busy, Fault}, 32'h0);
    rst = 1'b0;

    // Give every word a known value so the model covers the whole array.
    for (int i = 0; i < NB / 4; i++) issue(1'b1, 3'b010, 32'(i * 4), $urandom, 1'b1);
    rel();
    drain();

    // Word store/load, then byte stores with sign/zero extension.
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1); rel();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1); rel();
    issue(1'b1, 3'b000, 32'h11, 32'h0000007F, 1'b1); rel();
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1); rel();
    issue(1'b1, 3'b000, 32'h11, 32'hAAAAAA80, 1'b1); rel();
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1); rel();
    issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b1); rel();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1); rel();
    // Faults: misaligned half/word, then confirm the word is untouched.
    issue(1'b0, 3'b001, 32'h13, 32'h0, 1'b1); rel();
    issue(1'b1, 3'b010, 32'h12, 32'h55555555, 1'b1); rel();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1); rel();
    drain();

    // Req held high across three loads, then Req pulsed during ACCESS.
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b1);
    rel();
    drain();
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
    rel();
    Req = 1'b1;
    ALUResult = 32'h44;
    @(negedge clk);
    Req = 1'b0;
    drain();

    // Reset mid-access drops the pending store.
    issue(1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0);
    @(posedge clk);
    @(negedge clk);
    Req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_flags", {29'h0, Ack, Busy, Fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1); rel();

    // Address aliasing and illegal width code.
    issue(1'b1, 3'b010, 32'((1 << AW) + 4), 32'hCAFEF00D, 1'b1); rel();
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1); rel();
    issue(1'b0, 3'b111, 32'h4, 32'h0, 1'b1); rel();
    issue(1'b1, 3'b101, 32'h8, 32'h0, 1'b1); rel();
    drain();

    // Randomized mix of back-to-back and idle-separated accesses.
    for (int i = 0; i < 400; i++) begin
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 2 * NB - 1);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
      issue(1'($urandom_range(0, 1)), f3, addr, $urandom, 1'b1);
      if ($urandom_range(0, 1) == 0) begin
        rel();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    rel();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
